// File: rtl/conv_sequencer_pkg.sv
// Shared constants for the 3x3 convolution sequencer: FSM encoding, kernel and window timing.
package conv_sequencer_pkg;

  // FSM state encoding
  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StRun    = 2'd1;
  localparam logic [1:0] StFinish = 2'd2;

  // Kernel geometry
  localparam int unsigned K    = 3;
  localparam int unsigned Taps = K * K;

  // One window: 9 read cycles, MAC cycles 1..9, write-back on the last phase
  localparam int unsigned WinLen = 11;
  localparam int unsigned PhaseW = 4;

  localparam logic [PhaseW-1:0] PhaseLastRd = PhaseW'(Taps - 1);
  localparam logic [PhaseW-1:0] PhaseWrite  = PhaseW'(WinLen - 1);

endpackage

// File: rtl/conv_addr_gen.sv
// Window row/col and tap-phase counters, plus the pixel, weight and output addresses they imply.
module conv_addr_gen
  import conv_sequencer_pkg::*;
#(
  parameter int unsigned IMG_W  = 8,
  parameter int unsigned IMG_H  = 8,
  parameter int unsigned PIX_AW = 6,
  parameter int unsigned OUT_AW = 6
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              step_i,
  output logic [PhaseW-1:0] phase_o,
  output logic              last_win_o,
  output logic [PIX_AW-1:0] pix_addr_o,
  output logic [3:0]        wt_addr_o,
  output logic [OUT_AW-1:0] out_addr_o
);

  localparam int unsigned RowW = $clog2(IMG_H);
  localparam int unsigned ColW = $clog2(IMG_W);

  localparam logic [RowW-1:0] RowLast = RowW'(IMG_H - 3);
  localparam logic [ColW-1:0] ColLast = ColW'(IMG_W - 3);

  logic [PhaseW-1:0] phase_d, phase_q;
  logic [RowW-1:0]   row_d, row_q;
  logic [ColW-1:0]   col_d, col_q;
  logic [1:0]        dr, dc;
  logic [31:0]       pix_lin, out_lin;
  logic              win_end;

  assign win_end    = step_i && (phase_q == PhaseWrite);
  assign last_win_o = (row_q == RowLast) && (col_q == ColLast);

  // Counter next state: phase wraps every window, col then row advance raster-order
  always_comb begin
    phase_d = phase_q;
    row_d   = row_q;
    col_d   = col_q;
    if (clear_i) begin
      phase_d = '0;
      row_d   = '0;
      col_d   = '0;
    end else if (step_i) begin
      phase_d = win_end ? '0 : phase_q + 1'b1;
      if (win_end && !last_win_o) begin
        if (col_q == ColLast) begin
          col_d = '0;
          row_d = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
    end
  end

  // Counter state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      phase_q <= phase_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // Tap phase -> kernel row/col offset (phase/3, phase%3) without a divider
  always_comb begin
    dr = 2'd0;
    dc = 2'd0;
    unique case (phase_q)
      4'd0: begin dr = 2'd0; dc = 2'd0; end
      4'd1: begin dr = 2'd0; dc = 2'd1; end
      4'd2: begin dr = 2'd0; dc = 2'd2; end
      4'd3: begin dr = 2'd1; dc = 2'd0; end
      4'd4: begin dr = 2'd1; dc = 2'd1; end
      4'd5: begin dr = 2'd1; dc = 2'd2; end
      4'd6: begin dr = 2'd2; dc = 2'd0; end
      4'd7: begin dr = 2'd2; dc = 2'd1; end
      4'd8: begin dr = 2'd2; dc = 2'd2; end
      default: begin dr = 2'd0; dc = 2'd0; end
    endcase
  end

  // Linear addresses, computed at 32 bits so no intermediate can overflow
  always_comb begin
    pix_lin = (32'(row_q) + 32'(dr)) * 32'(IMG_W) + 32'(col_q) + 32'(dc);
    out_lin = 32'(row_q) * 32'(IMG_W - 2) + 32'(col_q);
  end

  assign phase_o    = phase_q;
  assign pix_addr_o = PIX_AW'(pix_lin);
  assign out_addr_o = OUT_AW'(out_lin);
  assign wt_addr_o  = phase_q;

endmodule

// File: rtl/conv_sequencer.sv
// Controller that walks a 3x3 kernel over the image, driving memories and the processing unit.
module conv_sequencer
  import conv_sequencer_pkg::*;
#(
  parameter int unsigned IMG_W  = 8,
  parameter int unsigned IMG_H  = 8,
  parameter int unsigned PIX_AW = 6,
  parameter int unsigned OUT_AW = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              pix_rd_en,
  output logic [PIX_AW-1:0] pix_addr,
  output logic              wt_rd_en,
  output logic [3:0]        wt_addr,
  output logic              pu_start,
  input  logic              pu_done,
  input  logic [15:0]       pu_result,
  output logic              out_wr_en,
  output logic [OUT_AW-1:0] out_addr,
  output logic [15:0]       out_data
);

  logic [1:0]        state_d, state_q;
  logic              error_d, error_q;
  logic              accept, in_run, rd_phase, wr_phase;
  logic [PhaseW-1:0] phase;
  logic              last_win;
  logic [PIX_AW-1:0] gen_pix_addr;
  logic [3:0]        gen_wt_addr;
  logic [OUT_AW-1:0] gen_out_addr;

  assign accept   = (state_q == StIdle) && start;
  assign in_run   = (state_q == StRun);
  assign rd_phase = in_run && (phase <= PhaseLastRd);
  assign wr_phase = in_run && (phase == PhaseWrite);

  conv_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .PIX_AW(PIX_AW),
    .OUT_AW(OUT_AW)
  ) u_addr_gen (
    .clk_i     (clk),
    .rst_ni    (reset_n),
    .clear_i   (accept),
    .step_i    (in_run),
    .phase_o   (phase),
    .last_win_o(last_win),
    .pix_addr_o(gen_pix_addr),
    .wt_addr_o (gen_wt_addr),
    .out_addr_o(gen_out_addr)
  );

  // FSM next state and sticky missing-done flag
  always_comb begin
    state_d = state_q;
    error_d = error_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          error_d = 1'b0;
        end
      end
      StRun: begin
        if (phase == PhaseWrite) begin
          if (!pu_done) error_d = 1'b1;
          if (last_win) state_d = StFinish;
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM and error state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      error_q <= error_d;
    end
  end

  // Outputs are pure decodes of reset-cleared state, so reset zeroes them without waiting a clock
  always_comb begin
    busy      = (state_q != StIdle);
    done      = (state_q == StFinish);
    error     = error_q;
    pix_rd_en = rd_phase;
    wt_rd_en  = rd_phase;
    pix_addr  = rd_phase ? gen_pix_addr : '0;
    wt_addr   = rd_phase ? gen_wt_addr : '0;
    pu_start  = in_run && (phase != '0) && (phase != PhaseWrite);
    out_wr_en = wr_phase;
    out_addr  = wr_phase ? gen_out_addr : '0;
    out_data  = wr_phase ? pu_result : '0;
  end

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench: memory and PU models around conv_sequencer, scoreboard of expected writes.
module tb_conv_sequencer;

  localparam int IMG_W  = 8;
  localparam int IMG_H  = 8;
  localparam int PIX_AW = 6;
  localparam int OUT_AW = 6;
  localparam int OW     = IMG_W - 2;
  localparam int NWIN   = (IMG_W - 2) * (IMG_H - 2);
  localparam int LAT    = NWIN * 11 + 1;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              busy, done, error;
  logic              pix_rd_en, wt_rd_en, pu_start, pu_done, out_wr_en;
  logic [PIX_AW-1:0] pix_addr;
  logic [3:0]        wt_addr;
  logic [OUT_AW-1:0] out_addr;
  logic [15:0]       pu_result, out_data;

  conv_sequencer #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .PIX_AW(PIX_AW),
    .OUT_AW(OUT_AW)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .pix_rd_en(pix_rd_en),
    .pix_addr (pix_addr),
    .wt_rd_en (wt_rd_en),
    .wt_addr  (wt_addr),
    .pu_start (pu_start),
    .pu_done  (pu_done),
    .pu_result(pu_result),
    .out_wr_en(out_wr_en),
    .out_addr (out_addr),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  // Memories with one-cycle read latency
  logic [7:0] pix_mem [64];
  logic [7:0] wt_mem  [16];
  logic [7:0] pix_q = 8'd0;
  logic [7:0] wt_q  = 8'd0;

  always @(posedge clk) begin
    if (pix_rd_en) pix_q <= pix_mem[pix_addr];
    if (wt_rd_en)  wt_q  <= wt_mem[wt_addr];
  end

  function automatic logic [15:0] mul8(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] sa, sb;
    sa = {{8{a[7]}}, a};
    sb = {{8{b[7]}}, b};
    return 16'(sa * sb);
  endfunction

  // Processing-unit model: MAC while start_pu high, clears when low, done after 9 MACs
  logic [15:0] acc = 16'd0;
  logic [3:0]  cnt = 4'd0;
  int          win_idx = 0;
  bit          withhold5 = 1'b0;

  always @(posedge clk) begin
    if (!pu_start) begin
      acc <= 16'd0;
      cnt <= 4'd0;
    end else begin
      acc <= acc + mul8(pix_q, wt_q);
      cnt <= cnt + 4'd1;
    end
    if (!busy) win_idx <= 0;
    else if (out_wr_en) win_idx <= win_idx + 1;
  end

  assign pu_done   = (cnt == 4'd9) && !(withhold5 && win_idx == 5);
  assign pu_result = acc;

  // Reference 3x3 convolution with 16-bit wrap
  function automatic logic [15:0] conv_ref(input int r, input int c);
    logic [15:0] s;
    s = 16'd0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s = s + mul8(pix_mem[(r + i) * IMG_W + c + j], wt_mem[i * 3 + j]);
    return s;
  endfunction

  typedef struct {
    int          addr;
    logic [15:0] data;
  } exp_t;

  exp_t        sb [$];
  logic [15:0] obs_data [NWIN];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_strobes"}, {pix_rd_en, wt_rd_en, pu_start, out_wr_en}, 4'b0);
    chk({tag, "_addrs"}, {pix_addr, wt_addr, out_addr, out_data}, '0);
  endtask

  task automatic fill_const(input logic [7:0] pv, input logic [7:0] wv);
    for (int i = 0; i < 64; i++) pix_mem[i] = pv;
    for (int i = 0; i < 16; i++) wt_mem[i] = (i < 9) ? wv : 8'd0;
  endtask

  // Runs one image; abort_at > 0 returns right after sampling that cycle
  task automatic run_frame(input int abort_at, input bit extra_starts);
    int writes, dones, w, c;
    exp_t e;
    sb.delete();
    for (int r = 0; r < IMG_H - 2; r++)
      for (int cc = 0; cc < OW; cc++) begin
        e.addr = r * OW + cc;
        e.data = conv_ref(r, cc);
        sb.push_back(e);
      end
    writes = 0;
    dones  = 0;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int n = 1; n <= LAT + 3; n++) begin
      if (n < LAT) begin
        w = (n - 1) / 11;
        c = (n - 1) % 11;
        chk("busy_run", busy, 1'b1);
        chk("rd_en", {pix_rd_en, wt_rd_en}, (c <= 8) ? 2'b11 : 2'b00);
        if (c <= 8) begin
          chk("pix_addr", pix_addr, ((w / OW) + c / 3) * IMG_W + (w % OW) + c % 3);
          chk("wt_addr", wt_addr, c);
        end
        chk("pu_start", pu_start, (c >= 1 && c <= 9));
        chk("wr_en", out_wr_en, c == 10);
      end
      chk("done_time", done, n == LAT);
      chk("error_t", error, withhold5 && n >= 67);
      if (done) dones++;
      if (n == LAT) chk("busy_fin", busy, 1'b1);
      if (n > LAT) chk("busy_idle", busy, 1'b0);
      if (out_wr_en) begin
        writes++;
        if (sb.size() == 0) begin
          chk("sb_extra_write", 1'b1, 1'b0);
        end else begin
          e = sb.pop_front();
          chk("out_addr", out_addr, e.addr);
          chk("out_data", out_data, e.data);
          if (e.addr < NWIN) obs_data[e.addr] = out_data;
        end
      end
      if (n == abort_at) return;
      start = extra_starts && (n == 3 || n == 150 || n == 395);
      tick();
    end
    start = 1'b0;
    chk("sb_empty", sb.size(), 0);
    chk("writes", writes, NWIN);
    chk("dones", dones, 1);
  endtask

  initial begin
    fill_const(8'd1, 8'd1);
    #3;
    chk_quiet("rst_async");
    chk("rst_error", error, 1'b0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk_quiet("post_rst");

    // All-ones image: every output 9
    run_frame(0, 1'b0);
    chk("ones_out0", obs_data[0], 16'd9);
    chk("ones_err", error, 1'b0);

    // Pixel = address, centre weight only: output is the centre pixel
    for (int i = 0; i < 64; i++) pix_mem[i] = 8'(i);
    for (int i = 0; i < 16; i++) wt_mem[i] = (i == 4) ? 8'd1 : 8'd0;
    run_frame(0, 1'b0);
    chk("ctr_addr0", obs_data[0], 16'd9);
    chk("ctr_addr35", obs_data[35], 16'd54);
    chk("ctr_addr7", obs_data[7], 16'd18);

    // Most-negative operands, with ignored start pulses while busy
    fill_const(8'h80, 8'h80);
    run_frame(0, 1'b1);
    chk("neg_out35", obs_data[35], 16'h4000);

    // Missing pu_done on window 5 sets sticky error but writes continue
    fill_const(8'd1, 8'd1);
    withhold5 = 1'b1;
    run_frame(0, 1'b0);
    chk("err_sticky", error, 1'b1);
    withhold5 = 1'b0;
    // Next start clears it (checked every cycle inside run_frame)
    run_frame(0, 1'b0);

    // Reset in window 10, phase 4
    run_frame(115, 1'b0);
    chk("abort_phase", {pix_rd_en, pix_addr}, {1'b1, 6'(((10 / OW) + 1) * IMG_W + (10 % OW) + 1)});
    reset_n = 1'b0;
    #1;
    chk_quiet("mid_rst");
    chk("mid_rst_err", error, 1'b0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_quiet("after_rel");
    end
    run_frame(0, 1'b0);
    chk("fresh_out0", obs_data[0], 16'd9);
    chk("fresh_err", error, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute bound so a stuck run still ends
  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
